multi_cycle_ctrl: RTL and testbench

//  Control FSM of the multi-cycle CPU: sequences IF/ID/EXE/MEM/WB per instruction, drives every datapath select/enable.

---
 rtl/mcpu_defs.sv | 55 +++++
 rtl/mcpu_op_decode.sv | 45 ++++
 rtl/multi_cycle_ctrl.sv | 138 +++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mcpu_defs.sv
// Shared definitions for the multi-cycle CPU: opcodes, FSM state encodings and
// the select codes that the datapath muxes decode.
package mcpu_defs;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLTI  = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_BLTZ  = 6'b110110;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_L   = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] PC_NEXT = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JR   = 2'b10;
  localparam logic [1:0] PC_JMP  = 2'b11;

  localparam logic [1:0] RD_RA = 2'b00;
  localparam logic [1:0] RD_RT = 2'b01;
  localparam logic [1:0] RD_RD = 2'b10;

  typedef enum logic [3:0] {
    CL_NOP, CL_ALU_R, CL_ALU_I, CL_BEQ, CL_BNE, CL_BLTZ,
    CL_LW, CL_SW, CL_J, CL_JR, CL_JAL, CL_HALT
  } iclass_e;

endpackage

// File: rtl/mcpu_op_decode.sv
// Opcode decoder: instruction class plus the selects that depend only on op.
// HALT_EN makes 111111 a halt instruction; otherwise it decodes as a NOP.
module mcpu_op_decode
  import mcpu_defs::*;
(
  input  logic [5:0] op,
  output iclass_e    cls,
  output logic [2:0] alu_op,
  output logic       alu_src_a,
  output logic       alu_src_b,
  output logic       ext_sel
);

  // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
  always_comb begin
    cls       = CL_NOP;
    alu_op    = ALU_ADD;
    alu_src_b = 1'b0;
    alu_src_a = (op == OP_SLL);
    ext_sel   = !(op == OP_ANDI || op == OP_ORI);
    case (op)
      OP_ADD:   cls = CL_ALU_R;
      OP_SUB:   begin cls = CL_ALU_R; alu_op = ALU_SUB; end
      OP_AND:   begin cls = CL_ALU_R; alu_op = ALU_AND; end
      OP_SLL:   begin cls = CL_ALU_R; alu_op = ALU_SLL; end
      OP_ADDIU: begin cls = CL_ALU_I; alu_src_b = 1'b1; end
      OP_ANDI:  begin cls = CL_ALU_I; alu_src_b = 1'b1; alu_op = ALU_AND; end
      OP_ORI:   begin cls = CL_ALU_I; alu_src_b = 1'b1; alu_op = ALU_OR; end
      OP_SLTI:  begin cls = CL_ALU_I; alu_src_b = 1'b1; alu_op = ALU_SLT; end
      OP_LW:    cls = CL_LW;
      OP_SW:    cls = CL_SW;
      OP_BEQ:   cls = CL_BEQ;
      OP_BNE:   cls = CL_BNE;
      OP_BLTZ:  cls = CL_BLTZ;
      OP_J:     cls = CL_J;
      OP_JR:    cls = CL_JR;
      OP_JAL:   cls = CL_JAL;
`ifdef HALT_EN
      OP_HALT:  cls = CL_HALT;
`endif
      default:  cls = CL_NOP;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control FSM: sequences IF/ID/EXE/MEM/WB and drives all
// datapath enables and selects. HALT_EN enables the HALT instruction.
module multi_cycle_ctrl
  import mcpu_defs::*;
#(
  parameter int OP_W    = 6,
  parameter int STATE_W = 3
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [OP_W-1:0]    op,
  input  logic               zero,
  input  logic               sign,
  output logic               PCWre,
  output logic               IRWre,
  output logic               RegWre,
  output logic [1:0]         RegDst,
  output logic               WrRegDSrc,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic [2:0]         ALUOp,
  output logic               ExtSel,
  output logic               mRD,
  output logic               mWR,
  output logic               DBDataSrc,
  output logic [1:0]         PCSrc,
  output logic [STATE_W-1:0] state
);

  state_e     cur;
  iclass_e    cls;
  logic [2:0] dec_alu_op;
  logic       dec_src_a;
  logic       dec_src_b;
  logic       dec_ext;
  logic       taken;

  mcpu_op_decode u_decode (
    .op        (op),
    .cls       (cls),
    .alu_op    (dec_alu_op),
    .alu_src_a (dec_src_a),
    .alu_src_b (dec_src_b),
    .ext_sel   (dec_ext)
  );

  assign state = cur;
  assign taken = (cls == CL_BEQ && zero) || (cls == CL_BNE && !zero) || (cls == CL_BLTZ && sign);

  // NOTE: state is the only register; non-blocking assignment keeps edge semantics exact.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cur <= S_IF;
    end else begin
      case (cur)
        S_IF: cur <= S_ID;
        S_ID: begin
          case (cls)
            CL_ALU_R, CL_ALU_I:        cur <= S_EXE_AL;
            CL_BEQ, CL_BNE, CL_BLTZ:   cur <= S_EXE_BR;
            CL_LW, CL_SW:              cur <= S_EXE_LS;
            CL_HALT:                   cur <= S_ID;
            default:                   cur <= S_IF;
          endcase
        end
        S_EXE_AL: cur <= S_WB_AL;
        S_EXE_LS: cur <= S_MEM;
        S_MEM:    cur <= (cls == CL_LW) ? S_WB_L : S_IF;
        default:  cur <= S_IF;
      endcase
    end
  end

  // Outputs are combinational and gated by RST so a write strobe drops in the same cycle.
  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    RegDst    = RD_RA;
    WrRegDSrc = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = ALU_ADD;
    ExtSel    = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    DBDataSrc = 1'b0;
    PCSrc     = PC_NEXT;
    if (!RST) begin
      ALUSrcA = dec_src_a;
      ExtSel  = dec_ext;
      case (cur)
        S_IF: IRWre = 1'b1;
        S_ID: begin
          case (cls)
            CL_J:  begin PCSrc = PC_JMP; PCWre = 1'b1; end
            CL_JR: begin PCSrc = PC_JR;  PCWre = 1'b1; end
            CL_JAL: begin
              RegWre = 1'b1; RegDst = RD_RA; WrRegDSrc = 1'b0;
              PCSrc  = PC_JMP; PCWre = 1'b1;
            end
            CL_ALU_R, CL_ALU_I, CL_BEQ, CL_BNE, CL_BLTZ, CL_LW, CL_SW, CL_HALT: ;
            default: PCWre = 1'b1;
          endcase
        end
        S_EXE_AL: begin
          ALUOp = dec_alu_op; ALUSrcB = dec_src_b;
        end
        S_WB_AL: begin
          ALUOp  = dec_alu_op; ALUSrcB = dec_src_b;
          RegWre = 1'b1; WrRegDSrc = 1'b1; PCWre = 1'b1;
          RegDst = (cls == CL_ALU_R) ? RD_RD : RD_RT;
        end
        S_EXE_BR: begin
          ALUOp = ALU_SUB; PCWre = 1'b1;
          PCSrc = taken ? PC_BR : PC_NEXT;
        end
        S_EXE_LS: begin
          ALUOp = ALU_ADD; ALUSrcB = 1'b1; ExtSel = 1'b1;
        end
        S_MEM: begin
          ALUOp = ALU_ADD; ALUSrcB = 1'b1; ExtSel = 1'b1;
          if (cls == CL_SW) begin
            mWR = 1'b1; PCWre = 1'b1;
          end else begin
            mRD = 1'b1;
          end
        end
        S_WB_L: begin
          ALUOp  = ALU_ADD; ALUSrcB = 1'b1; ExtSel = 1'b1;
          RegWre = 1'b1; RegDst = RD_RT; DBDataSrc = 1'b1; WrRegDSrc = 1'b1; PCWre = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Testbench for multi_cycle_ctrl: an instruction-level model expands each
// opcode into its expected per-cycle control vectors; one process compares.
module tb_multi_cycle_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic       pcwre, irwre, regwre;
    logic [1:0] regdst;
    logic       wrsrc, mrd, mwr, dbsrc;
    logic [1:0] pcsrc;
  } ctl_t;

  typedef struct packed {
    logic       srca, srcb;
    logic [2:0] aluop;
    logic       ext;
  } alu_t;

  typedef struct {
    ctl_t c;
    alu_t a;
    bit   care;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [5:0] op = 6'b0;
  logic       zero = 1'b0;
  logic       sign = 1'b0;
  logic       PCWre, IRWre, RegWre, WrRegDSrc, ALUSrcA, ALUSrcB, ExtSel;
  logic       mRD, mWR, DBDataSrc;
  logic [1:0] RegDst, PCSrc;
  logic [2:0] ALUOp, state;

  int   tests = 0;
  int   failed = 0;
  int   cyc = 0;
  bit   done = 1'b0;
  exp_t exp_q[$];
  exp_t mq[$];

  multi_cycle_ctrl dut (
    .CLK(CLK), .RST(RST), .op(op), .zero(zero), .sign(sign),
    .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .RegDst(RegDst),
    .WrRegDSrc(WrRegDSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .ExtSel(ExtSel), .mRD(mRD), .mWR(mWR), .DBDataSrc(DBDataSrc),
    .PCSrc(PCSrc), .state(state)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  function automatic exp_t blank(input logic [2:0] st);
    exp_t e;
    e.c = '0;
    e.a = '0;
    e.care = 1'b0;
    e.c.st = st;
    return e;
  endfunction

  function automatic logic [2:0] alu_code(input logic [5:0] o);
    case (o)
      6'b000001:           return 3'b001;
      6'b010000, 6'b010001: return 3'b100;
      6'b010010:           return 3'b011;
      6'b011000:           return 3'b010;
      6'b100111:           return 3'b101;
      default:             return 3'b000;
    endcase
  endfunction

  // Expand one instruction into the control vector of each of its cycles.
  function automatic void build(input logic [5:0] o, input logic z, input logic s);
    exp_t e;
    bit alu_r, alu_i, br, taken;
    mq.delete();
    alu_r = (o == 6'b000000 || o == 6'b000001 || o == 6'b010000 || o == 6'b011000);
    alu_i = (o == 6'b000010 || o == 6'b010001 || o == 6'b010010 || o == 6'b100111);
    br    = (o == 6'b110100 || o == 6'b110101 || o == 6'b110110);
    taken = (o == 6'b110100 && z) || (o == 6'b110101 && !z) || (o == 6'b110110 && s);
    e = blank(3'b000); e.c.irwre = 1'b1; mq.push_back(e);
    e = blank(3'b001);
    if (alu_r || alu_i) begin
      mq.push_back(e);
      e = blank(3'b110); e.care = 1'b1;
      e.a.aluop = alu_code(o); e.a.srcb = alu_i; e.a.srca = (o == 6'b011000);
      e.a.ext = !(o == 6'b010001 || o == 6'b010010);
      mq.push_back(e);
      e = blank(3'b111);
      e.c.regwre = 1'b1; e.c.regdst = alu_r ? 2'b10 : 2'b01; e.c.wrsrc = 1'b1; e.c.pcwre = 1'b1;
      mq.push_back(e);
    end else if (br) begin
      mq.push_back(e);
      e = blank(3'b101); e.care = 1'b1; e.a.aluop = 3'b001; e.a.ext = 1'b1;
      e.c.pcsrc = taken ? 2'b01 : 2'b00; e.c.pcwre = 1'b1;
      mq.push_back(e);
    end else if (o == 6'b110000 || o == 6'b110001) begin
      mq.push_back(e);
      e = blank(3'b010); e.care = 1'b1; e.a.srcb = 1'b1; e.a.ext = 1'b1;
      mq.push_back(e);
      e = blank(3'b011);
      if (o == 6'b110000) begin
        e.c.mwr = 1'b1; e.c.pcwre = 1'b1; mq.push_back(e);
      end else begin
        e.c.mrd = 1'b1; mq.push_back(e);
        e = blank(3'b100);
        e.c.regwre = 1'b1; e.c.regdst = 2'b01; e.c.dbsrc = 1'b1; e.c.wrsrc = 1'b1; e.c.pcwre = 1'b1;
        mq.push_back(e);
      end
    end else if (o == 6'b111000) begin
      e.c.pcsrc = 2'b11; e.c.pcwre = 1'b1; mq.push_back(e);
    end else if (o == 6'b111001) begin
      e.c.pcsrc = 2'b10; e.c.pcwre = 1'b1; mq.push_back(e);
    end else if (o == 6'b111010) begin
      e.c.regwre = 1'b1; e.c.regdst = 2'b00; e.c.wrsrc = 1'b0;
      e.c.pcsrc = 2'b11; e.c.pcwre = 1'b1; mq.push_back(e);
    end else begin
      e.c.pcwre = 1'b1; mq.push_back(e);
    end
  endfunction

  // Driver sits at posedge+1 at the start of an sIF cycle.
  task automatic run(input logic [5:0] o, input logic z, input logic s, input int want_cycles);
    op = o; zero = z; sign = s;
    build(o, z, s);
    check($sformatf("cycles_op%b", o), mq.size(), want_cycles);
    foreach (mq[i]) exp_q.push_back(mq[i]);
    repeat (mq.size()) @(posedge CLK);
    #1;
  endtask

  // Single compare process: reset vector while RST is high, model vector otherwise.
  always @(negedge CLK) begin
    ctl_t ac;
    alu_t aa;
    exp_t e;
    ac = '{state, PCWre, IRWre, RegWre, RegDst, WrRegDSrc, mRD, mWR, DBDataSrc, PCSrc};
    aa = '{ALUSrcA, ALUSrcB, ALUOp, ExtSel};
    cyc++;
    if (RST) begin
      check($sformatf("cyc%0d_reset_ctl", cyc), 32'(ac), 32'(ctl_t'('0)));
      check($sformatf("cyc%0d_reset_sel", cyc), 32'(aa), 32'(alu_t'('0)));
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("cyc%0d_ctl", cyc), 32'(ac), 32'(e.c));
      if (e.care) check($sformatf("cyc%0d_alu", cyc), 32'(aa), 32'(e.a));
    end else if (!done) begin
      tests++;
      failed++;
      $display("FAIL cyc%0d_model_underflow: got no expectation, expected one per cycle", cyc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge CLK);
    @(posedge CLK); #1 RST = 1'b0;

    // Hand-computed pins on the model itself.
    build(6'b110001, 1'b0, 1'b0);
    check("pin_lw_mem_state", mq[3].c.st, 3'b011);
    check("pin_lw_mem_mrd", mq[3].c.mrd, 1'b1);
    check("pin_lw_wb_dbsrc", mq[4].c.dbsrc, 1'b1);
    build(6'b111010, 1'b0, 1'b0);
    check("pin_jal_id_pcsrc", mq[1].c.pcsrc, 2'b11);
    check("pin_jal_id_regdst", mq[1].c.regdst, 2'b00);
    build(6'b000000, 1'b0, 1'b0);
    check("pin_add_wb_regdst", mq[3].c.regdst, 2'b10);

    run(6'b000000, 1'b0, 1'b0, 4);  // ADD
    run(6'b000001, 1'b1, 1'b0, 4);  // SUB
    run(6'b000010, 1'b0, 1'b0, 4);  // ADDIU
    run(6'b010000, 1'b0, 1'b0, 4);  // AND
    run(6'b010001, 1'b0, 1'b0, 4);  // ANDI
    run(6'b010010, 1'b0, 1'b0, 4);  // ORI
    run(6'b011000, 1'b0, 1'b0, 4);  // SLL
    run(6'b100111, 1'b0, 1'b1, 4);  // SLTI
    run(6'b110001, 1'b0, 1'b0, 5);  // LW
    run(6'b110000, 1'b0, 1'b0, 4);  // SW
    run(6'b110100, 1'b1, 1'b0, 3);  // BEQ taken
    run(6'b110100, 1'b0, 1'b0, 3);  // BEQ not taken
    run(6'b110101, 1'b0, 1'b0, 3);  // BNE taken
    run(6'b110101, 1'b1, 1'b1, 3);  // BNE not taken
    run(6'b110110, 1'b0, 1'b1, 3);  // BLTZ taken
    run(6'b110110, 1'b1, 1'b0, 3);  // BLTZ not taken
    run(6'b111000, 1'b0, 1'b0, 2);  // J
    run(6'b111001, 1'b0, 1'b0, 2);  // JR
    run(6'b111010, 1'b0, 1'b0, 2);  // JAL
    run(6'b000011, 1'b0, 1'b0, 2);  // undefined -> NOP

`ifdef HALT_EN
    op = 6'b111111;
    exp_q.push_back(blank(3'b000));
    exp_q[exp_q.size()-1].c.irwre = 1'b1;
    repeat (21) exp_q.push_back(blank(3'b001));
    repeat (22) @(posedge CLK);
    #1;
    check("halt_state_held", state, 3'b001);
    check("halt_pcwre", PCWre, 1'b0);
    RST = 1'b1; #1;
    check("halt_reset_state", state, 3'b000);
    @(negedge CLK);
    @(posedge CLK); #1 RST = 1'b0;
`else
    run(6'b111111, 1'b0, 1'b0, 2);  // HALT decodes as NOP
`endif

    // Reset during sMEM of SW: strobe must drop immediately.
    op = 6'b110000;
    build(6'b110000, 1'b0, 1'b0);
    check("sw_model_cycles", mq.size(), 4);
    for (int i = 0; i < 3; i++) exp_q.push_back(mq[i]);
    repeat (3) @(posedge CLK);
    #1;
    check("sw_mem_state", state, 3'b011);
    check("sw_mem_mwr", mWR, 1'b1);
    RST = 1'b1; #1;
    check("rst_mwr_drop", mWR, 1'b0);
    check("rst_state", state, 3'b000);
    check("rst_irwre", IRWre, 1'b0);
    check("rst_pcwre", PCWre, 1'b0);
    @(negedge CLK);
    @(posedge CLK); #1 RST = 1'b0;

    run(6'b000000, 1'b0, 1'b0, 4);  // ADD after reset recovery
    done = 1'b1;
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
